exec_unit: RTL and testbench

Execute stage of the 8-bit accumulator CPU. It sits directly downstream of the fetcher and accepts one fetched instruction byte at a time over a valid/ready handshake. It owns the accumulator and the zero/carry flags, and runs a multi-cycle data-memory handshake for memory operands. It returns a registered PC-load request for taken branches and halts permanently on HLT until reset.

---
 rtl/exec_unit.sv | 190 +++++++++++++++++++
 tb/tb_exec_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/exec_unit.sv
// Execute stage of the 8-bit accumulator CPU.
// Accepts one instruction byte per valid/ready handshake, owns the accumulator
// and zero/carry flags, runs a held-request data-memory handshake for memory
// operands, issues a one-cycle PC-load pulse for taken branches and stops
// permanently on HLT until reset.
module exec_unit #(
    parameter int BITS = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            instr_valid,
    input  logic [BITS-1:0] instr,
    output logic            instr_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic [BITS-1:0] mem_addr,
    output logic [BITS-1:0] mem_wdata,
    input  logic            mem_ack,
    input  logic [BITS-1:0] mem_rdata,
    output logic            pc_load,
    output logic [BITS-1:0] pc_target,
    output logic [BITS-1:0] acc,
    output logic            zero,
    output logic            carry,
    output logic            halted
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        HALT = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LDM  = 4'h2;
    localparam logic [3:0] OP_STM  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_SHL  = 4'h9;
    localparam logic [3:0] OP_SHR  = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_JZ   = 4'hC;
    localparam logic [3:0] OP_JC   = 4'hD;
    localparam logic [3:0] OP_LDIH = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    state_t          state;
    state_t          state_nxt;
    logic            accept;
    logic [3:0]      op;
    logic [3:0]      arg;
    logic [BITS-1:0] arg_ext;
    logic            op_is_mem;
    logic [3:0]      op_q;

    logic            reg_wr;
    logic [BITS-1:0] reg_acc;
    logic            reg_cwr;
    logic            reg_c;
    logic            br_taken;

    logic [BITS:0]   sum;
    logic [BITS:0]   diff;
    logic            alu_wr;
    logic [BITS-1:0] alu_acc;
    logic            alu_cwr;
    logic            alu_c;

    assign op        = instr[BITS-1:BITS-4];
    assign arg       = instr[3:0];
    assign arg_ext   = {{(BITS-4){1'b0}}, arg};
    assign op_is_mem = (op >= OP_LDM) && (op <= OP_XOR);

    // State register; reset always lands in IDLE, including from HALT.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake decode; ready only while idle.
    always_comb begin
        state_nxt   = state;
        instr_ready = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                instr_ready = 1'b1;
                accept      = instr_valid;
                if (instr_valid) begin
                    if (op == OP_HLT)   state_nxt = HALT;
                    else if (op_is_mem) state_nxt = MEM;
                end
            end
            MEM:     if (mem_ack) state_nxt = IDLE;
            HALT:    state_nxt = HALT;
            default: state_nxt = IDLE;
        endcase
    end

    // Single-cycle register ops and branch decision from the current flags.
    always_comb begin
        reg_wr   = 1'b0;
        reg_acc  = acc;
        reg_cwr  = 1'b0;
        reg_c    = carry;
        br_taken = 1'b0;
        case (op)
            OP_LDI:  begin reg_wr = 1'b1; reg_acc = arg_ext; end
            OP_SHL:  begin reg_wr = 1'b1; reg_acc = {acc[BITS-2:0], 1'b0};
                           reg_cwr = 1'b1; reg_c = acc[BITS-1]; end
            OP_SHR:  begin reg_wr = 1'b1; reg_acc = {1'b0, acc[BITS-1:1]};
                           reg_cwr = 1'b1; reg_c = acc[0]; end
            OP_LDIH: begin reg_wr = 1'b1; reg_acc = {arg, acc[BITS-5:0]}; end
            OP_JMP:  br_taken = 1'b1;
            OP_JZ:   br_taken = zero;
            OP_JC:   br_taken = carry;
            default: ;
        endcase
    end

    // Memory-operand result, selected by the opcode latched at accept.
    // The extra top bit of sum/diff is the carry-out / borrow.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, mem_rdata};
        diff    = {1'b0, acc} - {1'b0, mem_rdata};
        alu_wr  = 1'b1;
        alu_acc = acc;
        alu_cwr = 1'b0;
        alu_c   = carry;
        case (op_q)
            OP_LDM:  alu_acc = mem_rdata;
            OP_ADD:  begin alu_acc = sum[BITS-1:0];  alu_cwr = 1'b1; alu_c = sum[BITS];  end
            OP_SUB:  begin alu_acc = diff[BITS-1:0]; alu_cwr = 1'b1; alu_c = diff[BITS]; end
            OP_AND:  alu_acc = acc & mem_rdata;
            OP_OR:   alu_acc = acc | mem_rdata;
            OP_XOR:  alu_acc = acc ^ mem_rdata;
            default: alu_wr = 1'b0;
        endcase
    end

    // Architectural state, memory request and branch pulse updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            zero      <= 1'b0;
            carry     <= 1'b0;
            pc_load   <= 1'b0;
            pc_target <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            halted    <= 1'b0;
            op_q      <= '0;
        end else begin
            pc_load <= 1'b0;
            if (accept) begin
                if (reg_wr) begin
                    acc  <= reg_acc;
                    zero <= (reg_acc == '0);
                end
                if (reg_cwr) carry <= reg_c;
                if (br_taken) begin
                    pc_load   <= 1'b1;
                    pc_target <= arg_ext;
                end
                if (op_is_mem) begin
                    mem_req   <= 1'b1;
                    mem_we    <= (op == OP_STM);
                    mem_addr  <= arg_ext;
                    mem_wdata <= acc;
                    op_q      <= op;
                end
                if (op == OP_HLT) halted <= 1'b1;
            end
            if ((state == MEM) && mem_ack) begin
                mem_req <= 1'b0;
                if (alu_wr) begin
                    acc  <= alu_acc;
                    zero <= (alu_acc == '0);
                end
                if (alu_cwr) carry <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: directed scenarios plus a randomized instruction stream
// checked against an integer-arithmetic model of the instruction set.
module tb_exec_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       mem_req;
    logic       mem_we;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_ack;
    logic [7:0] mem_rdata;
    logic       pc_load;
    logic [7:0] pc_target;
    logic [7:0] acc;
    logic       zero;
    logic       carry;
    logic       halted;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_acc;
    bit m_zero;
    bit m_carry;

    // observations captured while executing one instruction
    int         o_req_cycles;
    logic [7:0] o_addr;
    logic [7:0] o_wdata;
    logic       o_we;
    logic       o_stable;
    logic       o_rdy_low;
    logic       o_pc_load;
    logic [7:0] o_pc_target;

    exec_unit #(.BITS(8)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .pc_load(pc_load), .pc_target(pc_target),
        .acc(acc), .zero(zero), .carry(carry), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit is_mem(input int op);
        return (op >= 2) && (op <= 8);
    endfunction

    task automatic model_step(input int op, input int arg, input int rd, output bit taken);
        taken = 1'b0;
        case (op)
            1:  m_acc = arg;
            2:  m_acc = rd;
            4:  begin m_carry = (m_acc + rd) > 255; m_acc = (m_acc + rd) % 256; end
            5:  begin m_carry = m_acc < rd; m_acc = (m_acc - rd + 256) % 256; end
            6:  m_acc = m_acc & rd;
            7:  m_acc = m_acc | rd;
            8:  m_acc = m_acc ^ rd;
            9:  begin m_carry = m_acc >= 128; m_acc = (m_acc * 2) % 256; end
            10: begin m_carry = (m_acc % 2) == 1; m_acc = m_acc / 2; end
            11: taken = 1'b1;
            12: taken = m_zero;
            13: taken = m_carry;
            14: m_acc = arg * 16 + m_acc % 16;
            default: ;
        endcase
        if (op inside {1, 2, 4, 5, 6, 7, 8, 9, 10, 14}) m_zero = (m_acc == 0);
    endtask

    // Present one instruction; for memory ops answer with rd after wait_n
    // non-ack cycles while pushing junk instructions that must be ignored.
    // Returns at #1 after the final edge of the instruction.
    task automatic exec_instr(input logic [7:0] ins, input logic [7:0] rd, input int wait_n);
        int op;
        op = int'(ins[7:4]);
        instr_valid = 1'b1;
        instr = ins;
        @(posedge clk); #1;
        o_pc_load    = pc_load;
        o_pc_target  = pc_target;
        o_req_cycles = 0;
        o_stable     = 1'b1;
        o_rdy_low    = 1'b1;
        o_addr       = mem_addr;
        o_we         = mem_we;
        o_wdata      = mem_wdata;
        if (is_mem(op)) begin
            instr = 8'($urandom);
            for (int i = 0; i <= wait_n; i++) begin
                if (mem_req) o_req_cycles++;
                if (instr_ready) o_rdy_low = 1'b0;
                if ({mem_addr, mem_we, mem_wdata} !== {o_addr, o_we, o_wdata}) o_stable = 1'b0;
                if (i == wait_n) begin
                    mem_ack = 1'b1; mem_rdata = rd;
                end else begin
                    mem_ack = 1'b0; mem_rdata = 8'($urandom);
                end
                @(posedge clk); #1;
            end
            mem_ack = 1'b0;
        end
        instr_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1; instr_valid = 1'b0; mem_ack = 1'b0;
        instr = 8'h00; mem_rdata = 8'h00;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++;
        if ({acc, zero, carry, halted} !== 11'h000) begin
            n_err++; $display("FAIL reset_arch: got acc=%h z=%b c=%b h=%b want 00/0/0/0", acc, zero, carry, halted);
        end
        n_cmp++;
        if ({mem_req, mem_we, mem_addr, mem_wdata} !== 18'h0) begin
            n_err++; $display("FAIL reset_mem: got req=%b we=%b addr=%h wdata=%h want all 0", mem_req, mem_we, mem_addr, mem_wdata);
        end
        n_cmp++;
        if ({pc_load, pc_target, instr_ready} !== 10'b0_00000000_1) begin
            n_err++; $display("FAIL reset_pc_ready: got pcl=%b tgt=%h rdy=%b want 0/00/1", pc_load, pc_target, instr_ready);
        end
    endtask

    task automatic test_reg_ops();
        exec_instr(8'h15, 8'h00, 0);
        n_cmp++;
        if ({acc, instr_ready} !== {8'h05, 1'b1}) begin
            n_err++; $display("FAIL ldi5: got acc=%h rdy=%b want 05/1", acc, instr_ready);
        end
        exec_instr(8'hEA, 8'h00, 0);
        n_cmp++;
        if ({acc, zero, instr_ready} !== {8'hA5, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL ldih_a: got acc=%h z=%b rdy=%b want A5/0/1", acc, zero, instr_ready);
        end
    endtask

    task automatic test_add_carry();
        exec_instr(8'h1F, 8'h00, 0);
        exec_instr(8'hEF, 8'h00, 0);
        n_cmp++;
        if (acc !== 8'hFF) begin
            n_err++; $display("FAIL acc_ff: got %h want ff", acc);
        end
        exec_instr(8'h43, 8'h01, 2);
        n_cmp++;
        if (o_req_cycles !== 3) begin
            n_err++; $display("FAIL add_req_cycles: got %0d want 3", o_req_cycles);
        end
        n_cmp++;
        if ({o_addr, o_we, o_stable, o_rdy_low} !== {8'h03, 1'b0, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL add_req_fields: got addr=%h we=%b stable=%b rdylow=%b want 03/0/1/1", o_addr, o_we, o_stable, o_rdy_low);
        end
        n_cmp++;
        if ({acc, carry, zero, mem_req, instr_ready} !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL add_result: got acc=%h c=%b z=%b req=%b rdy=%b want 00/1/1/0/1", acc, carry, zero, mem_req, instr_ready);
        end
    endtask

    task automatic test_sub_stm();
        exec_instr(8'h13, 8'h00, 0);
        exec_instr(8'h50, 8'h05, 0);
        n_cmp++;
        if ({acc, carry, zero, o_req_cycles[3:0]} !== {8'hFE, 1'b1, 1'b0, 4'd1}) begin
            n_err++; $display("FAIL sub_borrow: got acc=%h c=%b z=%b req=%0d want fe/1/0/1", acc, carry, zero, o_req_cycles);
        end
        exec_instr(8'h37, 8'h99, 1);
        n_cmp++;
        if ({o_we, o_wdata, o_addr} !== {1'b1, 8'hFE, 8'h07}) begin
            n_err++; $display("FAIL stm_req: got we=%b wdata=%h addr=%h want 1/fe/07", o_we, o_wdata, o_addr);
        end
        n_cmp++;
        if ({acc, carry, zero} !== {8'hFE, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL stm_nochange: got acc=%h c=%b z=%b want fe/1/0", acc, carry, zero);
        end
    endtask

    task automatic test_branch();
        exec_instr(8'h10, 8'h00, 0);
        exec_instr(8'hC9, 8'h00, 0);
        n_cmp++;
        if ({o_pc_load, o_pc_target} !== {1'b1, 8'h09}) begin
            n_err++; $display("FAIL jz_taken: got pcl=%b tgt=%h want 1/09", o_pc_load, o_pc_target);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (pc_load !== 1'b0) begin
            n_err++; $display("FAIL jz_pulse_len: got pcl=%b want 0", pc_load);
        end
        exec_instr(8'hA0, 8'h00, 0);
        n_cmp++;
        if ({carry, zero} !== 2'b01) begin
            n_err++; $display("FAIL shr_zero: got c=%b z=%b want 0/1", carry, zero);
        end
        exec_instr(8'hD4, 8'h00, 0);
        n_cmp++;
        if (o_pc_load !== 1'b0) begin
            n_err++; $display("FAIL jc_not_taken: got pcl=%b want 0", o_pc_load);
        end
        exec_instr(8'hE8, 8'h00, 0);
        exec_instr(8'h90, 8'h00, 0);
        n_cmp++;
        if ({acc, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin
            n_err++; $display("FAIL shl_80: got acc=%h c=%b z=%b want 00/1/1", acc, carry, zero);
        end
    endtask

    task automatic test_halt();
        exec_instr(8'h1C, 8'h00, 0);
        exec_instr(8'hF0, 8'h00, 0);
        n_cmp++;
        if ({halted, instr_ready} !== 2'b10) begin
            n_err++; $display("FAIL hlt_enter: got h=%b rdy=%b want 1/0", halted, instr_ready);
        end
        instr_valid = 1'b1; instr = 8'h11; mem_ack = 1'b1; mem_rdata = 8'h77;
        repeat (4) @(posedge clk);
        #1;
        n_cmp++;
        if ({acc, halted, instr_ready, mem_req} !== {8'h0C, 1'b1, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL hlt_hold: got acc=%h h=%b rdy=%b req=%b want 0c/1/0/0", acc, halted, instr_ready, mem_req);
        end
        mem_ack = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; instr_valid = 1'b0;
        n_cmp++;
        if ({halted, acc, instr_ready} !== {1'b0, 8'h00, 1'b1}) begin
            n_err++; $display("FAIL hlt_reset: got h=%b acc=%h rdy=%b want 0/00/1", halted, acc, instr_ready);
        end
    endtask

    task automatic test_reset_in_mem();
        exec_instr(8'hE8, 8'h00, 0);
        exec_instr(8'h90, 8'h00, 0);
        instr_valid = 1'b1; instr = 8'h26;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_err++; $display("FAIL ldm_req: got req=%b want 1", mem_req);
        end
        @(posedge clk); #1;
        reset = 1'b1; mem_ack = 1'b1; mem_rdata = 8'h55;
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, acc, zero, carry, instr_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
            n_err++; $display("FAIL reset_in_mem: got req=%b acc=%h z=%b c=%b rdy=%b want 0/00/0/0/1", mem_req, acc, zero, carry, instr_ready);
        end
    endtask

    task automatic test_random();
        int op, arg, rd, wn, pre_acc;
        bit taken;
        logic [7:0] ins;
        do_reset();
        m_acc = 0; m_zero = 1'b0; m_carry = 1'b0;
        for (int k = 0; k < 300; k++) begin
            op  = $urandom_range(0, 14);
            arg = $urandom_range(0, 15);
            rd  = $urandom_range(0, 255);
            wn  = $urandom_range(0, 3);
            ins = {4'(op), 4'(arg)};
            pre_acc = m_acc;
            model_step(op, arg, rd, taken);
            exec_instr(ins, 8'(rd), wn);
            n_cmp++;
            if ({acc, zero, carry} !== {8'(m_acc), m_zero, m_carry}) begin
                n_err++; $display("FAIL rnd_state[%0d] ins=%h: got acc=%h z=%b c=%b want %h/%b/%b", k, ins, acc, zero, carry, 8'(m_acc), m_zero, m_carry);
            end
            n_cmp++;
            if (o_pc_load !== taken) begin
                n_err++; $display("FAIL rnd_pcload[%0d] ins=%h: got %b want %b", k, ins, o_pc_load, taken);
            end
            if (taken) begin
                n_cmp++;
                if (o_pc_target !== 8'(arg)) begin
                    n_err++; $display("FAIL rnd_target[%0d]: got %h want %h", k, o_pc_target, 8'(arg));
                end
            end
            if (is_mem(op)) begin
                n_cmp++;
                if ({o_addr, o_we, o_wdata} !== {8'(arg), op == 3, 8'(pre_acc)}) begin
                    n_err++; $display("FAIL rnd_memreq[%0d] ins=%h: got addr=%h we=%b wd=%h want %h/%b/%h", k, ins, o_addr, o_we, o_wdata, 8'(arg), op == 3, 8'(pre_acc));
                end
                n_cmp++;
                if ({o_req_cycles, o_stable, o_rdy_low, mem_req, instr_ready} !== {wn + 1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
                    n_err++; $display("FAIL rnd_memhs[%0d]: got cyc=%0d stable=%b rdylow=%b req=%b rdy=%b want %0d/1/1/0/1", k, o_req_cycles, o_stable, o_rdy_low, mem_req, instr_ready, wn + 1);
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                mem_ack = 1'b1; mem_rdata = 8'($urandom);
                @(posedge clk); #1;
                mem_ack = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 8'h00;
        mem_ack = 1'b0; mem_rdata = 8'h00;
        test_reset();
        test_reg_ops();
        test_add_carry();
        test_sub_stm();
        test_branch();
        test_halt();
        test_reset_in_mem();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
